// File: rtl/sysinfo_pkg.sv
// Shared definitions for the system-information register block: widths,
// word offsets, CTRL bit positions and the address decoder.
package sysinfo_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 64;

  localparam logic [ADDR_W-1:0] ADDR_SYSTEM_ID    = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_TIMESTAMP    = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_VERSION      = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_UPTIME_LO    = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_UPTIME_HI    = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_CTRL         = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_STATUS       = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH_BASE = 4'd8;

  localparam int CTRL_CLEAR_BIT  = 0;
  localparam int CTRL_FREEZE_BIT = 1;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_SYSTEM_ID,
    SEL_TIMESTAMP,
    SEL_VERSION,
    SEL_UPTIME_LO,
    SEL_UPTIME_HI,
    SEL_CTRL,
    SEL_STATUS,
    SEL_SCRATCH
  } reg_sel_e;

  // Holes in the map (7 and scratch words beyond num_scratch) decode to SEL_NONE.
  function automatic reg_sel_e decode_addr(input logic [ADDR_W-1:0] addr,
                                           input int num_scratch);
    reg_sel_e sel;
    sel = SEL_NONE;
    case (addr)
      ADDR_SYSTEM_ID: sel = SEL_SYSTEM_ID;
      ADDR_TIMESTAMP: sel = SEL_TIMESTAMP;
      ADDR_VERSION:   sel = SEL_VERSION;
      ADDR_UPTIME_LO: sel = SEL_UPTIME_LO;
      ADDR_UPTIME_HI: sel = SEL_UPTIME_HI;
      ADDR_CTRL:      sel = SEL_CTRL;
      ADDR_STATUS:    sel = SEL_STATUS;
      default: begin
        if (addr >= ADDR_SCRATCH_BASE &&
            int'(addr - ADDR_SCRATCH_BASE) < num_scratch) begin
          sel = SEL_SCRATCH;
        end
      end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sysinfo_uptime_counter.sv
// 64-bit free-running uptime counter with clear, freeze and an upper-word
// shadow that is captured whenever the low word is read.
module sysinfo_uptime_counter
  import sysinfo_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              freeze_we_i,
  input  logic              freeze_i,
  input  logic              latch_i,
  output logic [DATA_W-1:0] count_lo_o,
  output logic [DATA_W-1:0] shadow_o,
  output logic              freeze_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              freeze_q, freeze_d;

  // Clear wins over freeze so a combined clear+freeze write parks the count at 0.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    freeze_d = freeze_q;
    if (freeze_we_i) freeze_d = freeze_i;
    if (clear_i) begin
      cnt_d = '0;
    end else if (!freeze_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (latch_i) shadow_d = cnt_q[CNT_W-1:DATA_W];
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      freeze_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      freeze_q <= freeze_d;
    end
  end

  assign count_lo_o = cnt_q[DATA_W-1:0];
  assign shadow_o   = shadow_q;
  assign freeze_o   = freeze_q;

endmodule

// File: rtl/sysinfo_regs.sv
// System-information register slave: build constants, uptime counter with
// CTRL/STATUS, and a small bank of byte-writable scratch words.
module sysinfo_regs
  import sysinfo_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID   = 32'h5AA5_0001,
  parameter logic [31:0] TIMESTAMP   = 32'd0,
  parameter logic [31:0] VERSION     = 32'h0001_0000,
  parameter int          NUM_SCRATCH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [3:0]        byteenable,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);

  // Bus contract: no backpressure. A read or write strobe is accepted in the
  // cycle it is high; an accepted read returns readdata with readdatavalid
  // exactly one cycle later. When both strobes are high only the read happens.
  reg_sel_e          sel;
  logic              rd_en, wr_en, ctrl_we;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] scratch_q [NUM_SCRATCH];
  logic [DATA_W-1:0] scratch_d [NUM_SCRATCH];
  logic [DATA_W-1:0] uptime_lo, uptime_shadow;
  logic              freeze;

  assign sel     = decode_addr(address, NUM_SCRATCH);
  assign rd_en   = read;
  assign wr_en   = write & ~read;
  assign ctrl_we = wr_en && (sel == SEL_CTRL) && byteenable[0];

  sysinfo_uptime_counter u_uptime (
    .clock_i     (clock),
    .reset_i     (reset),
    .clear_i     (ctrl_we & writedata[CTRL_CLEAR_BIT]),
    .freeze_we_i (ctrl_we),
    .freeze_i    (writedata[CTRL_FREEZE_BIT]),
    .latch_i     (rd_en && (sel == SEL_UPTIME_LO)),
    .count_lo_o  (uptime_lo),
    .shadow_o    (uptime_shadow),
    .freeze_o    (freeze)
  );

  always_comb begin
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      scratch_d[i] = scratch_q[i];
      if (wr_en && (sel == SEL_SCRATCH) && (address[2:0] == 3'(i))) begin
        for (int b = 0; b < 4; b++) begin
          if (byteenable[b]) scratch_d[i][8*b +: 8] = writedata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      SEL_SYSTEM_ID: rd_mux = SYSTEM_ID;
      SEL_TIMESTAMP: rd_mux = TIMESTAMP;
      SEL_VERSION:   rd_mux = VERSION;
      SEL_UPTIME_LO: rd_mux = uptime_lo;
      SEL_UPTIME_HI: rd_mux = uptime_shadow;
      SEL_CTRL:      rd_mux = {30'b0, freeze, 1'b0};
      SEL_STATUS:    rd_mux = {27'b0, 4'(NUM_SCRATCH), freeze};
      SEL_SCRATCH: begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
          if (address[2:0] == 3'(i)) rd_mux = scratch_q[i];
        end
      end
      default:       rd_mux = '0;
    endcase
  end

  always_comb begin
    rvalid_d = rd_en;
    rdata_d  = rd_en ? rd_mux : rdata_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= scratch_d[i];
    end
  end

  // Masking by reset kills a response still in flight when reset rises
  // mid-stream, so nothing appears valid while reset is held.
  assign readdatavalid = rvalid_q & ~reset;
  assign readdata      = reset ? '0 : rdata_q;

endmodule
